// File: rtl/pls_pio_pkg.sv
// Shared constants for the parametrised Avalon-MM PIO: register map,
// edge-capture condition selectors and IRQ mode selectors.
package pls_pio_pkg;

  typedef enum logic [2:0] {
    PIO_ADDR_DATA    = 3'd0,
    PIO_ADDR_DIR     = 3'd1,
    PIO_ADDR_IRQMASK = 3'd2,
    PIO_ADDR_EDGECAP = 3'd3,
    PIO_ADDR_OUTSET  = 3'd4,
    PIO_ADDR_OUTCLR  = 3'd5
  } pio_addr_e;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_EDGE  = 0;
  localparam int unsigned IRQ_LEVEL = 1;

endpackage

// File: rtl/pls_pio_sync.sv
// Multi-stage synchroniser bringing asynchronous pin inputs into the clk
// domain; every stage resets to zero.
module pls_pio_sync #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_sync
);

  logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign d_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pls_hpi_pio_ext.sv
// Avalon-MM parallel I/O port: data/direction registers with atomic set/clear,
// synchronised inputs, sticky edge capture and a maskable interrupt.
module pls_hpi_pio_ext
  import pls_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned           IRQ_MODE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] ecap_q, ecap_d;
  logic [DATA_WIDTH-1:0] in_prev_q, in_prev_d;
  logic [2:0]            arm_cnt_q, arm_cnt_d;
  logic [31:0]           readdata_q, readdata_d;

  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] ecap_clr;
  logic [DATA_WIDTH-1:0] edges;
  logic [DATA_WIDTH-1:0] port_rd;
  logic [31:0]           wd_unused;
  logic                  wr_en;
  logic                  armed;

  pls_pio_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in    (in_port),
    .d_sync  (in_sync)
  );

  // Only the low DATA_WIDTH bits of the bus are meaningful.
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign wd_unused = writedata;

  // Edge detection stays off until the synchroniser and in_prev hold real pin
  // history, so pins already high at reset release do not look like edges.
  assign armed = (arm_cnt_q == ARM_CYCLES);

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
    in_prev_d = in_sync;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edges = ~in_sync & in_prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edges = in_sync ^ in_prev_q;
    end else begin
      edges = in_sync & ~in_prev_q;
    end
    if (!armed) begin
      edges = '0;
    end
  end

  always_comb begin
    wr_en      = chipselect & ~write_n;
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    ecap_clr   = '0;
    if (wr_en) begin
      case (address)
        PIO_ADDR_DATA:    data_out_d = wd;
        PIO_ADDR_DIR:     dir_d      = wd;
        PIO_ADDR_IRQMASK: mask_d     = wd;
        PIO_ADDR_EDGECAP: ecap_clr   = wd;
        PIO_ADDR_OUTSET:  data_out_d = data_out_q | wd;
        PIO_ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
        default: ;
      endcase
    end
    // A new edge outranks a write-1-clear landing on the same bit.
    ecap_d = (ecap_q & ~ecap_clr) | edges;
  end

  always_comb begin
    port_rd = (dir_q & data_out_q) | (~dir_q & in_sync);
    case (address)
      PIO_ADDR_DATA:    readdata_d = 32'(port_rd);
      PIO_ADDR_DIR:     readdata_d = 32'(dir_q);
      PIO_ADDR_IRQMASK: readdata_d = 32'(mask_q);
      PIO_ADDR_EDGECAP: readdata_d = 32'(ecap_q);
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      ecap_q     <= '0;
      in_prev_q  <= '0;
      arm_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      ecap_q     <= ecap_d;
      in_prev_q  <= in_prev_d;
      arm_cnt_q  <= arm_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_out_q;
  assign out_oe   = dir_q;
  assign irq      = (IRQ_MODE == IRQ_LEVEL) ? |(in_sync & mask_q) : |(ecap_q & mask_q);

endmodule

// File: tb/tb_pls_hpi_pio_ext.sv
// Bench for pls_hpi_pio_ext: two instances (edge/rising/2-stage and
// level/any-edge/3-stage) on one bus, checked against a pin-history model.
module tb_pls_hpi_pio_ext;

  localparam int S1 = 2;
  localparam int S2 = 3;
  localparam logic [15:0] RV = 16'h1234;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [15:0] in_port = '0;
  logic [31:0] rd1, rd2;
  logic [15:0] op1, op2, oe1, oe2;
  logic        irq1, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pls_hpi_pio_ext #(
    .DATA_WIDTH(16), .RESET_VALUE(RV), .SYNC_STAGES(S1), .EDGE_TYPE(0), .IRQ_MODE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port),
    .out_port(op1), .out_oe(oe1), .irq(irq1)
  );

  pls_hpi_pio_ext #(
    .DATA_WIDTH(16), .RESET_VALUE(RV), .SYNC_STAGES(S2), .EDGE_TYPE(2), .IRQ_MODE(1)
  ) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
    .out_port(op2), .out_oe(oe2), .irq(irq2)
  );

  // Reference model: samp[k] is the pin value seen at the k-th clock after
  // reset release; a depth-s synchroniser shows samp[k-s+1] after clock k.
  logic [15:0] samp [0:4095];
  int          n;
  logic [15:0] m_data, m_dir, m_mask, m_ec1, m_ec2;
  logic [31:0] m_rd1, m_rd2;

  function automatic logic [15:0] sync_at(input int k, input int s);
    if (k >= s) return samp[k-s+1];
    return '0;
  endfunction

  function automatic logic [15:0] edge_of(input int et, input logic [15:0] cur,
                                          input logic [15:0] prev);
    if (et == 1) return ~cur & prev;
    if (et == 2) return cur ^ prev;
    return cur & ~prev;
  endfunction

  function automatic logic [31:0] rd_of(input logic [2:0] a, input logic [15:0] pins,
                                        input logic [15:0] ec, input logic [15:0] d,
                                        input logic [15:0] dir, input logic [15:0] mk);
    case (a)
      3'd0:    return {16'h0, (dir & d) | (~dir & pins)};
      3'd1:    return {16'h0, dir};
      3'd2:    return {16'h0, mk};
      3'd3:    return {16'h0, ec};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [15:0] e1, e2, clr, w;
    if (!reset_n) begin
      m_data = RV; m_dir = '0; m_mask = '0; m_ec1 = '0; m_ec2 = '0;
      m_rd1 = '0; m_rd2 = '0; n = 0;
    end else begin
      if (n < 4095) n = n + 1;
      samp[n] = in_port;
      m_rd1 = rd_of(address, sync_at(n-1, S1), m_ec1, m_data, m_dir, m_mask);
      m_rd2 = rd_of(address, sync_at(n-1, S2), m_ec2, m_data, m_dir, m_mask);
      e1 = (n >= S1 + 2) ? edge_of(0, sync_at(n-1, S1), sync_at(n-2, S1)) : '0;
      e2 = (n >= S2 + 2) ? edge_of(2, sync_at(n-1, S2), sync_at(n-2, S2)) : '0;
      clr = '0;
      w = writedata[15:0];
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = w;
          3'd1: m_dir = w;
          3'd2: m_mask = w;
          3'd3: clr = w;
          3'd4: m_data = m_data | w;
          3'd5: m_data = m_data & ~w;
          default: ;
        endcase
      end
      m_ec1 = (m_ec1 & ~clr) | e1;
      m_ec2 = (m_ec2 & ~clr) | e2;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd got %h exp 00000000", rd1); end
    n_cmp++; if (op1 !== RV) begin n_bad++; $display("FAIL reset_out got %h exp %h", op1, RV); end
    n_cmp++; if (oe1 !== 16'h0 || oe2 !== 16'h0) begin n_bad++; $display("FAIL reset_oe got %h/%h exp 0000", oe1, oe2); end
    n_cmp++; if (irq1 !== 1'b0 || irq2 !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b/%b exp 0", irq1, irq2); end
    reset_n = 1'b1;
  endtask

  task automatic test_data_dir();
    bus_wr(3'd0, 32'h0000_A5A5);
    bus_wr(3'd1, 32'h0000_FFFF);
    bus_rd(3'd0);
    n_cmp++; if (rd1 !== 32'h0000_A5A5) begin n_bad++; $display("FAIL data_rd got %h exp 0000a5a5", rd1); end
    n_cmp++; if (op1 !== 16'hA5A5) begin n_bad++; $display("FAIL data_out got %h exp a5a5", op1); end
    n_cmp++; if (oe1 !== 16'hFFFF) begin n_bad++; $display("FAIL dir_oe got %h exp ffff", oe1); end
    bus_rd(3'd1);
    n_cmp++; if (rd2 !== 32'h0000_FFFF) begin n_bad++; $display("FAIL dir_rd got %h exp 0000ffff", rd2); end
  endtask

  task automatic test_set_clear();
    bus_wr(3'd0, 32'h0000_00F0);
    bus_wr(3'd4, 32'h0000_0003);
    n_cmp++; if (op1 !== 16'h00F3) begin n_bad++; $display("FAIL outset got %h exp 00f3", op1); end
    bus_wr(3'd5, 32'h0000_00F0);
    n_cmp++; if (op1 !== 16'h0003) begin n_bad++; $display("FAIL outclr got %h exp 0003", op1); end
    bus_rd(3'd4);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL rd_outset got %h exp 0", rd1); end
    bus_wr(3'd6, 32'h0000_FFFF);
    bus_rd(3'd7);
    n_cmp++; if (op1 !== 16'h0003 || rd1 !== 32'h0) begin n_bad++; $display("FAIL reserved got out %h rd %h exp 0003/0", op1, rd1); end
    bus_wr(3'd0, 32'hFFFF_0005);
    bus_rd(3'd0);
    n_cmp++; if (rd1 !== 32'h0000_0005) begin n_bad++; $display("FAIL upper_bits got %h exp 00000005", rd1); end
  endtask

  task automatic test_edge_irq();
    in_port = '0;
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd2, 32'h1);
    tick(5);
    bus_wr(3'd3, 32'hFFFF);
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL edge_idle irq got %b exp 0", irq1); end
    in_port = 16'h0001;
    tick(S1);
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL edge_early irq got %b exp 0", irq1); end
    tick(1);
    n_cmp++; if (irq1 !== 1'b1) begin n_bad++; $display("FAIL edge_irq got %b exp 1", irq1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0000_0001) begin n_bad++; $display("FAIL edge_cap got %h exp 00000001", rd1); end
    bus_wr(3'd3, 32'h1);
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL edge_clr irq got %b exp 0", irq1); end
  endtask

  task automatic test_set_wins();
    in_port = '0;
    tick(6);
    bus_wr(3'd3, 32'hFFFF);
    in_port = 16'h0001;
    tick(S1);
    bus_wr(3'd3, 32'h1);
    n_cmp++; if (irq1 !== 1'b1) begin n_bad++; $display("FAIL set_wins irq got %b exp 1", irq1); end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h1) begin n_bad++; $display("FAIL set_wins cap got %h exp 00000001", rd1); end
    bus_wr(3'd3, 32'h1);
    in_port = '0;
    tick(6);
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL falling_ignored irq got %b exp 0", irq1); end
  endtask

  task automatic test_static_high();
    in_port = 16'hFFFF;
    do_reset();
    bus_wr(3'd2, 32'hFFFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL static_high irq cyc %0d got %b exp 0", i, irq1); end
    end
    bus_rd(3'd3);
    n_cmp++; if (rd1 !== 32'h0 || rd2 !== 32'h0) begin n_bad++; $display("FAIL static_high cap got %h/%h exp 0", rd1, rd2); end
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL static_high level irq got %b exp 1", irq2); end
  endtask

  task automatic test_level_irq();
    in_port = '0;
    do_reset();
    bus_wr(3'd2, 32'h8000);
    tick(4);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_idle got %b exp 0", irq2); end
    in_port = 16'h8000;
    tick(S2 - 1);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_early got %b exp 0", irq2); end
    tick(1);
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL level_high got %b exp 1", irq2); end
    in_port = '0;
    tick(S2);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_low got %b exp 0", irq2); end
    in_port = 16'h8000;
    tick(S2 + 1);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (irq2 !== 1'b0 || rd2 !== 32'h0) begin n_bad++; $display("FAIL level_reset got irq %b rd %h exp 0", irq2, rd2); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] e_irq_src;
    in_port = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n_cmp++;
      e_irq_src = sync_at(n, S2) & m_mask;
      if (rd1 !== m_rd1 || rd2 !== m_rd2 || op1 !== m_data || oe1 !== m_dir ||
          irq1 !== |(m_ec1 & m_mask) || irq2 !== |e_irq_src) begin
        n_bad++;
        $display("FAIL rand cyc %0d got rd %h/%h out %h oe %h irq %b/%b exp rd %h/%h out %h oe %h irq %b/%b",
                 i, rd1, rd2, op1, oe1, irq1, irq2, m_rd1, m_rd2, m_data, m_dir,
                 |(m_ec1 & m_mask), |e_irq_src);
      end
      reset_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) == 0) in_port = 16'($urandom);
      address = 3'($urandom_range(0, 7));
      writedata = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_data_dir();
    test_set_clear();
    test_edge_irq();
    test_set_wins();
    test_static_high();
    test_level_irq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
